// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM state encoding.
package sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full-subtractor cell: x - y - bin -> difference bit d and borrow-out bout.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per clock,
// behind a start/busy/done handshake.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             d_c;
  logic             bout_c;

  // Single cell reused every RUN cycle on the current LSBs and the stored borrow.
  full_subtractor u_fs (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (br),
    .d    (d_c),
    .bout (bout_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      br     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= S_RUN;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          br   <= bout_c;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CNT_W'(1);
          // First RUN edge discards the previous result while shifting in bit 0.
          if (cnt == '0) diff <= {d_c, {(WIDTH-1){1'b0}}};
          else           diff <= {d_c, diff[WIDTH-1:1]};
          if (cnt == CNT_W'(WIDTH - 1)) begin
            borrow <= bout_c;
            state  <= S_DONE;
            done   <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
